// File: rtl/pulse_handshake_tx_pkg.sv
// Shared definitions for the pulse handshake link: FSM encoding, defaults and sizing helpers.
package pulse_handshake_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ_HI = 2'd1,
    ST_REQ_LO = 2'd2
  } hs_state_e;

  localparam int SYNC_STAGES_DFLT = 3;

  // Timer must be able to run past TIMEOUT-1 so a sticky error fires once per phase.
  function automatic int timer_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/pulse_handshake_tx_sync_ff_chain.sv
// N-flop level synchronizer with synchronous reset to 0; shared with the receiver side.
module sync_ff_chain #(
  parameter int STAGES = 3
) (
  input  logic CLK,
  input  logic RST,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] chain_r;

  // Shift the asynchronous level through the synchronizer stages.
  always_ff @(posedge CLK) begin
    if (RST) begin
      chain_r <= '0;
    end else begin
      chain_r <= {chain_r[STAGES-2:0], din};
    end
  end

  assign dout = chain_r[STAGES-1];

endmodule

// File: rtl/pulse_handshake_tx.sv
// Source side of a 4-phase req/ack pulse link: pending counter, handshake FSM and phase timer.
module pulse_handshake_tx
  import pulse_handshake_tx_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DFLT,
  parameter int CNT_W       = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SIG_I,
  input  logic             ACK_I,
  input  logic             ERR_CLR,
  output logic             REQ_O,
  output logic             BUSY,
  output logic [CNT_W-1:0] PEND,
  output logic             OVF,
  output logic             TO_ERR
);

  localparam int               TMR_W    = timer_width(TIMEOUT);
  localparam bit               TO_EN    = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};
  localparam logic [TMR_W-1:0] TMR_MAX  = {TMR_W{1'b1}};
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  hs_state_e        state_r, state_nx_s;
  logic [CNT_W-1:0] pend_r, pend_nx_s;
  logic [TMR_W-1:0] timer_r, timer_nx_s;
  logic             req_r, ovf_r, ovf_nx_s, to_err_r, to_err_nx_s;
  logic             ack_s, pend_nz_s, launch_s, waiting_s, inc_s, dec_s;

  sync_ff_chain #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .CLK  (CLK),
    .RST  (RST),
    .din  (ACK_I),
    .dout (ack_s)
  );

  assign pend_nz_s = (pend_r != {CNT_W{1'b0}});

  // Handshake sequencing; launch_s marks the cycle an event is committed to a new REQ.
  always_comb begin
    state_nx_s = state_r;
    launch_s   = 1'b0;
    waiting_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (SIG_I || pend_nz_s) begin
          state_nx_s = ST_REQ_HI;
          launch_s   = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_REQ_HI: begin
        if (ack_s) begin
          state_nx_s = ST_REQ_LO;
        end else begin
          state_nx_s = ST_REQ_HI;
          waiting_s  = 1'b1;
        end
      end
      ST_REQ_LO: begin
        if (!ack_s) begin
          if (SIG_I || pend_nz_s) begin
            state_nx_s = ST_REQ_HI;
            launch_s   = 1'b1;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end else begin
          state_nx_s = ST_REQ_LO;
          waiting_s  = 1'b1;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Pending counter: a launch drains the queue first, so a coincident SIG_I is queued instead.
  always_comb begin
    dec_s     = launch_s && pend_nz_s;
    inc_s     = SIG_I && !(launch_s && !pend_nz_s);
    pend_nx_s = pend_r;
    ovf_nx_s  = 1'b0;
    if (inc_s && !dec_s) begin
      if (pend_r == PEND_MAX) begin
        ovf_nx_s = 1'b1;
      end else begin
        pend_nx_s = pend_r + CNT_W'(1);
      end
    end else if (dec_s && !inc_s) begin
      pend_nx_s = pend_r - CNT_W'(1);
    end else begin
      pend_nx_s = pend_r;
    end
  end

  // Phase timer and sticky timeout flag; a new timeout beats a simultaneous clear.
  always_comb begin
    timer_nx_s  = timer_r;
    to_err_nx_s = to_err_r;
    if (state_nx_s != state_r) begin
      timer_nx_s = {TMR_W{1'b0}};
    end else if ((state_r != ST_IDLE) && (timer_r != TMR_MAX)) begin
      timer_nx_s = timer_r + TMR_W'(1);
    end else begin
      timer_nx_s = timer_r;
    end
    if (TO_EN && waiting_s && (timer_r == TMR_LAST)) begin
      to_err_nx_s = 1'b1;
    end else if (ERR_CLR) begin
      to_err_nx_s = 1'b0;
    end else begin
      to_err_nx_s = to_err_r;
    end
  end

  // State and output registers; REQ_O comes straight from req_r.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r  <= ST_IDLE;
      req_r    <= 1'b0;
      pend_r   <= {CNT_W{1'b0}};
      ovf_r    <= 1'b0;
      to_err_r <= 1'b0;
      timer_r  <= {TMR_W{1'b0}};
    end else begin
      state_r  <= state_nx_s;
      req_r    <= (state_nx_s == ST_REQ_HI);
      pend_r   <= pend_nx_s;
      ovf_r    <= ovf_nx_s;
      to_err_r <= to_err_nx_s;
      timer_r  <= timer_nx_s;
    end
  end

  assign REQ_O  = req_r;
  assign PEND   = pend_r;
  assign OVF    = ovf_r;
  assign TO_ERR = to_err_r;
  assign BUSY   = (state_r != ST_IDLE) || pend_nz_s;

endmodule

// File: tb/tb_pulse_handshake_tx.sv
// Directed bench for pulse_handshake_tx (CNT_W=2, TIMEOUT=16) with a behavioural receiver.
module tb_pulse_handshake_tx;

  logic       CLK, RST, SIG_I, ACK_I, ERR_CLR;
  logic       REQ_O, BUSY, OVF, TO_ERR;
  logic [1:0] PEND;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int hs_count  = 0;
  int snap;
  bit rx_en     = 1'b0;
  int rx_dly    = 1;
  logic req_prev = 1'b0;

  typedef struct {
    logic       rst, sig, ack;
    logic       exp_req;
    logic [1:0] exp_pend;
    logic       exp_busy, exp_ovf, exp_te;
  } vec_t;
  vec_t vecs[14];

  pulse_handshake_tx #(.SYNC_STAGES(3), .CNT_W(2), .TIMEOUT(16)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .SIG_I   (SIG_I),
    .ACK_I   (ACK_I),
    .ERR_CLR (ERR_CLR),
    .REQ_O   (REQ_O),
    .BUSY    (BUSY),
    .PEND    (PEND),
    .OVF     (OVF),
    .TO_ERR  (TO_ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Receiver model: follows REQ_O with rx_dly cycles of latency when enabled.
  initial begin
    ACK_I = 1'b0;
    forever begin
      @(posedge CLK);
      #2;
      if (rx_en) begin
        if (REQ_O && !ACK_I) begin
          if (rx_dly > 0) begin
            repeat (rx_dly) @(posedge CLK);
            #2;
          end
          ACK_I = 1'b1;
        end else if (!REQ_O && ACK_I) begin
          if (rx_dly > 0) begin
            repeat (rx_dly) @(posedge CLK);
            #2;
          end
          ACK_I = 1'b0;
        end
      end
    end
  end

  // Counts handshakes as rising edges of REQ_O.
  initial begin
    forever begin
      @(posedge CLK);
      #3;
      if (REQ_O === 1'b1 && req_prev === 1'b0) hs_count++;
      req_prev = REQ_O;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((BUSY !== 1'b0 || ACK_I !== 1'b0) && n < 400) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk({name, " idle"}, {31'd0, BUSY}, 32'd0);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge CLK);
      RST   = vecs[i].rst;
      SIG_I = vecs[i].sig;
      ACK_I = vecs[i].ack;
      @(posedge CLK);
      #1;
      chk($sformatf("vec%0d req", i),  {31'd0, REQ_O},  {31'd0, vecs[i].exp_req});
      chk($sformatf("vec%0d pend", i), {30'd0, PEND},   {30'd0, vecs[i].exp_pend});
      chk($sformatf("vec%0d busy", i), {31'd0, BUSY},   {31'd0, vecs[i].exp_busy});
      chk($sformatf("vec%0d ovf", i),  {31'd0, OVF},    {31'd0, vecs[i].exp_ovf});
      chk($sformatf("vec%0d toerr", i),{31'd0, TO_ERR}, {31'd0, vecs[i].exp_te});
    end
    @(negedge CLK);
    RST   = 1'b0;
    SIG_I = 1'b0;
  endtask

  initial begin
    //            rst   sig   ack   req   pend   busy  ovf   te
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0};

    RST = 1'b1; SIG_I = 1'b0; ERR_CLR = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst req",   {31'd0, REQ_O},  32'd0);
    chk("rst pend",  {30'd0, PEND},   32'd0);
    chk("rst busy",  {31'd0, BUSY},   32'd0);
    chk("rst ovf",   {31'd0, OVF},    32'd0);
    chk("rst toerr", {31'd0, TO_ERR}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // 1) single pulse, receiver latency 5
    rx_en = 1'b1; rx_dly = 5; snap = hs_count;
    @(negedge CLK); SIG_I = 1'b1;
    @(posedge CLK); #1;
    chk("t1 req rise", {31'd0, REQ_O}, 32'd1);
    @(negedge CLK); SIG_I = 1'b0;
    for (int k = 0; k < 50 && ACK_I !== 1'b1; k++) begin
      @(posedge CLK); #1;
    end
    chk("t1 ack seen", {31'd0, ACK_I}, 32'd1);
    repeat (2) begin @(posedge CLK); #1; end
    chk("t1 req held", {31'd0, REQ_O}, 32'd1);
    @(posedge CLK); #1;
    chk("t1 req fall", {31'd0, REQ_O}, 32'd0);
    wait_idle("t1");
    chk("t1 handshakes", 32'(hs_count - snap), 32'd1);

    // 2) four back-to-back events
    rx_dly = 1; snap = hs_count;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); SIG_I = 1'b1;
      @(posedge CLK); #1;
      chk($sformatf("t2 pend%0d", i), {30'd0, PEND}, 32'(i));
    end
    @(negedge CLK); SIG_I = 1'b0;
    wait_idle("t2");
    chk("t2 handshakes", 32'(hs_count - snap), 32'd4);
    chk("t2 pend end", {30'd0, PEND}, 32'd0);

    // 3) saturation with ack stuck low, then resume
    rx_en = 1'b0; snap = hs_count;
    run_vecs(0, 7);
    rx_en = 1'b1; rx_dly = 0;
    wait_idle("t3");
    chk("t3 handshakes", 32'(hs_count - snap), 32'd4);
    chk("t3 pend end", {30'd0, PEND}, 32'd0);

    // 5) reset mid-handshake with PEND=2, then relaunch
    rx_en = 1'b0;
    run_vecs(8, 13);
    rx_en = 1'b1; rx_dly = 1;
    wait_idle("t5");
    chk("t5 pend end", {30'd0, PEND}, 32'd0);

    // 4) timeout while REQ_HI, clear, then late ack
    rx_en = 1'b0; snap = hs_count;
    @(negedge CLK); SIG_I = 1'b1;
    @(posedge CLK); #1;
    chk("t4 req", {31'd0, REQ_O}, 32'd1);
    @(negedge CLK); SIG_I = 1'b0;
    repeat (15) @(posedge CLK);
    #1;
    chk("t4 toerr early", {31'd0, TO_ERR}, 32'd0);
    @(posedge CLK); #1;
    chk("t4 toerr set", {31'd0, TO_ERR}, 32'd1);
    chk("t4 req held", {31'd0, REQ_O}, 32'd1);
    repeat (3) @(posedge CLK);
    @(negedge CLK); ERR_CLR = 1'b1;
    @(posedge CLK); #1;
    chk("t4 toerr clr", {31'd0, TO_ERR}, 32'd0);
    @(negedge CLK); ERR_CLR = 1'b0;
    @(posedge CLK); #1;
    chk("t4 toerr stays", {31'd0, TO_ERR}, 32'd0);
    rx_en = 1'b1;
    wait_idle("t4");
    chk("t4 handshakes", 32'(hs_count - snap), 32'd1);
    chk("t4 toerr end", {31'd0, TO_ERR}, 32'd0);

    // 6) SIG_I in the exact cycle ack_s falls in REQ_LO
    rx_en = 1'b0; snap = hs_count;
    @(negedge CLK); SIG_I = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK); SIG_I = 1'b0; ACK_I = 1'b1;
    repeat (3) begin @(posedge CLK); #1; end
    chk("t6 req still hi", {31'd0, REQ_O}, 32'd1);
    @(posedge CLK); #1;
    chk("t6 req lo", {31'd0, REQ_O}, 32'd0);
    @(negedge CLK); ACK_I = 1'b0;
    repeat (3) begin @(posedge CLK); #1; end
    chk("t6 in req_lo", {31'd0, REQ_O}, 32'd0);
    @(negedge CLK); SIG_I = 1'b1;
    @(posedge CLK); #1;
    chk("t6 direct relaunch", {31'd0, REQ_O}, 32'd1);
    chk("t6 pend zero", {30'd0, PEND}, 32'd0);
    @(negedge CLK); SIG_I = 1'b0;
    rx_en = 1'b1;
    wait_idle("t6");
    chk("t6 handshakes", 32'(hs_count - snap), 32'd2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
